sdram_slot_scheduler: RTL and testbench

// - Time-slot scheduler sharing the single-port ip_sdram between the video line renderer (reads), the UART

---
 rtl/sdram_sched_pkg.sv | 8 +
 rtl/sdram_wr_fifo.sv | 49 ++++
 rtl/sdram_slot_scheduler.sv | 116 +++++++++++
 tb/tb_sdram_slot_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_sched_pkg.sv
// sdram_sched_pkg: slot-phase constants and the slot-8 command type shared by the SDRAM slot scheduler.
package sdram_sched_pkg;
    localparam logic [3:0] PH_RD_ISSUE  = 4'd0;
    localparam logic [3:0] PH_RD_CAPT   = 4'd7;
    localparam logic [3:0] PH_WR_SLOT   = 4'd8;
    localparam logic [3:0] PH_RD_SAMPLE = 4'd15;
    typedef enum logic [1:0] {CMD_NONE, CMD_WRITE, CMD_REFRESH} cmd_e;
endpackage

// File: rtl/sdram_wr_fifo.sv
// sdram_wr_fifo: small synchronous FIFO buffering {addr,data} UART writes until a write slot comes round.
module sdram_wr_fifo #(
    parameter int W    = 24,
    parameter int LOG2 = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LOG2:0] level_o
);
    logic [W-1:0]    mem_q [2**LOG2];
    logic [LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LOG2:0]   level_q, level_d;
    logic            push, pop;

    assign full_o  = level_q[LOG2];
    assign empty_o = level_q == '0;
    assign level_o = level_q;
    assign dout_o  = mem_q[rptr_q];

    always_comb begin
        push    = push_i && !full_o;
        pop     = pop_i && !empty_o;
        wptr_d  = wptr_q + LOG2'(push);
        rptr_d  = rptr_q + LOG2'(pop);
        level_d = level_q + (LOG2+1)'(push) - (LOG2+1)'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= din_i;
    end
endmodule

// File: rtl/sdram_slot_scheduler.sv
// sdram_slot_scheduler: 16-phase time-slot arbiter sharing ip_sdram between video reads (phase 0),
// buffered UART writes and auto-refresh (phase 8).
module sdram_slot_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int FIFO_LOG2 = 2,
    parameter int RFSH_MAX  = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               sync_i,
    output logic [3:0]         phase_o,
    input  logic               sdram_init_busy_i,
    input  logic               rd_req_i,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    output logic [7:0]         rd_data_o,
    output logic               rd_valid_o,
    input  logic               wr_valid_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [7:0]         wr_data_i,
    output logic               wr_ready_o,
    output logic [FIFO_LOG2:0] fifo_level_o,
    output logic               mreq_n_o,
    output logic               rd_n_o,
    output logic               wr_n_o,
    output logic               rfsh_n_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic [7:0]         wdata_o,
    input  logic [31:0]        rdata_i
);
    localparam int CW = $clog2(RFSH_MAX + 1);

    logic [3:0]        phase_q, phase_d;
    logic              rd_pend_q, rd_pend_d, rd_valid_q, rd_valid_d;
    logic [7:0]        rd_data_q, rd_data_d, wdata_q, wdata_d;
    logic              mreq_n_q, mreq_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, rfsh_n_q, rfsh_n_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [CW-1:0]     rfsh_cnt_q, rfsh_cnt_d;
    cmd_e              cmd_q, cmd_d;
    logic              rd_issue, slot, do_wr, capture, fifo_full, fifo_empty;
    logic [ADDR_W+7:0] head;

    // cmd_q is WRITE only during the phase-8 cycle that drove wr_n, so the pop follows a driven write only
    sdram_wr_fifo #(.W(ADDR_W + 8), .LOG2(FIFO_LOG2)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (wr_valid_i),
        .pop_i   (cmd_q == CMD_WRITE && phase_q == PH_WR_SLOT),
        .din_i   ({wr_addr_i, wr_data_i}),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    always_comb begin
        rd_issue   = phase_q == PH_RD_SAMPLE && rd_req_i && !sdram_init_busy_i && !sync_i;
        slot       = phase_q == PH_RD_CAPT && !sdram_init_busy_i && !sync_i;
        do_wr      = slot && !fifo_empty && rfsh_cnt_q < CW'(RFSH_MAX);
        capture    = phase_q == PH_RD_CAPT && rd_pend_q && !sync_i;
        phase_d    = sync_i ? PH_RD_ISSUE : phase_q + 4'd1;
        rd_pend_d  = rd_issue || (rd_pend_q && !capture && !sync_i);
        rd_valid_d = capture;
        rd_data_d  = capture ? rdata_i[{address_q[1:0], 3'b000} +: 8] : rd_data_q;
        cmd_d      = do_wr ? CMD_WRITE : slot ? CMD_REFRESH : CMD_NONE;
        mreq_n_d   = !(rd_issue || slot);
        rd_n_d     = !rd_issue;
        wr_n_d     = !do_wr;
        rfsh_n_d   = !(slot && !do_wr);
        address_d  = rd_issue ? rd_addr_i : do_wr ? head[ADDR_W+7:8] : address_q;
        wdata_d    = do_wr ? head[7:0] : wdata_q;
        rfsh_cnt_d = do_wr ? rfsh_cnt_q + CW'(1) : slot ? '0 : rfsh_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q    <= PH_RD_ISSUE;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            cmd_q      <= CMD_NONE;
            mreq_n_q   <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            rfsh_n_q   <= 1'b1;
            address_q  <= '0;
            wdata_q    <= '0;
            rfsh_cnt_q <= '0;
        end else begin
            phase_q    <= phase_d;
            rd_pend_q  <= rd_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            cmd_q      <= cmd_d;
            mreq_n_q   <= mreq_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            rfsh_n_q   <= rfsh_n_d;
            address_q  <= address_d;
            wdata_q    <= wdata_d;
            rfsh_cnt_q <= rfsh_cnt_d;
        end
    end

    assign phase_o    = phase_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign wr_ready_o = !fifo_full;
    assign mreq_n_o   = mreq_n_q;
    assign rd_n_o     = rd_n_q;
    assign wr_n_o     = wr_n_q;
    assign rfsh_n_o   = rfsh_n_q;
    assign address_o  = address_q;
    assign wdata_o    = wdata_q;
endmodule

// File: tb/tb_sdram_slot_scheduler.sv
// tb_sdram_slot_scheduler: directed-vector bench for the SDRAM slot scheduler.
module tb_sdram_slot_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sync, busy, rd_req, wr_valid, rd_valid, wr_ready;
    logic        mreq_n, rd_n, wr_n, rfsh_n;
    logic [3:0]  phase;
    logic [15:0] rd_addr, wr_addr, address;
    logic [7:0]  wr_data, rd_data, wdata;
    logic [2:0]  level;
    logic [31:0] rdata;

    int vectors = 0;
    int miscompares = 0;
    int rv_cnt = 0;
    byte slot_log[$];
    logic [23:0] wr_log[$];

    sdram_slot_scheduler dut (
        .clk_i(clk), .rst_ni(rst_n), .sync_i(sync), .phase_o(phase),
        .sdram_init_busy_i(busy), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .wr_valid_i(wr_valid),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
        .fifo_level_o(level), .mreq_n_o(mreq_n), .rd_n_o(rd_n), .wr_n_o(wr_n),
        .rfsh_n_o(rfsh_n), .address_o(address), .wdata_o(wdata), .rdata_i(rdata)
    );

    always #5 clk = ~clk;

    // values seen at a rising edge are those of the cycle just ending
    always @(posedge clk) begin
        if (phase == 4'd8) slot_log.push_back(!wr_n ? "W" : !rfsh_n ? "R" : "N");
        if (!wr_n) wr_log.push_back({address, wdata});
        if (rd_valid) rv_cnt++;
    end

    task automatic wait_phase(input logic [3:0] p);
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            if (phase == p) return;
        end
        vectors++; miscompares++;
        $display("FAIL wait_phase timeout waiting for phase %0d", p);
    endtask

    task automatic wait_slots(input int n);
        for (int i = 0; i < 200 && slot_log.size() < n; i++) @(negedge clk);
        vectors++; if (slot_log.size() < n) begin miscompares++; $display("FAIL wait_slots got=%0d exp=%0d", slot_log.size(), n); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++; if (phase !== 4'd0) begin miscompares++; $display("FAIL rst_phase got=%0d exp=0", phase); end
        vectors++; if ({mreq_n, rd_n, wr_n, rfsh_n} !== 4'hF) begin miscompares++; $display("FAIL rst_strobes got=%b exp=1111", {mreq_n, rd_n, wr_n, rfsh_n}); end
        vectors++; if (address !== 16'h0 || wdata !== 8'h0 || rd_data !== 8'h0) begin miscompares++; $display("FAIL rst_data got=%h/%h/%h exp=0", address, wdata, rd_data); end
        vectors++; if (rd_valid !== 1'b0 || level !== 3'd0 || wr_ready !== 1'b1) begin miscompares++; $display("FAIL rst_fifo got rv=%b lvl=%0d rdy=%b exp 0/0/1", rd_valid, level, wr_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_init_busy();
        int bad_strobe = 0, bad_phase = 0, rv0 = rv_cnt;
        logic [3:0] prev = phase;
        busy = 1'b1; rd_req = 1'b1; rd_addr = 16'h0555;
        for (int i = 0; i < 100; i++) begin
            wr_valid = i < 3;
            wr_addr = 16'h0100 + 16'(i);
            wr_data = 8'h11 * 8'(i + 1);
            @(negedge clk);
            if ({mreq_n, rd_n, wr_n, rfsh_n} !== 4'hF) bad_strobe++;
            if (phase !== prev + 4'd1) bad_phase++;
            prev = phase;
        end
        wr_valid = 1'b0; busy = 1'b0; rd_req = 1'b0;
        vectors++; if (bad_strobe != 0) begin miscompares++; $display("FAIL busy_strobes got=%0d low cycles exp=0", bad_strobe); end
        vectors++; if (bad_phase != 0) begin miscompares++; $display("FAIL busy_phase got=%0d bad steps exp=0", bad_phase); end
        vectors++; if (rv_cnt != rv0) begin miscompares++; $display("FAIL busy_rd_valid got=%0d pulses exp=0", rv_cnt - rv0); end
        vectors++; if (level !== 3'd3) begin miscompares++; $display("FAIL busy_level got=%0d exp=3", level); end
    endtask

    task automatic test_read();
        wait_phase(4'd8);
        vectors++; if (wr_n !== 1'b0 || address !== 16'h0100 || wdata !== 8'h11) begin miscompares++; $display("FAIL wr0 got wr_n=%b %h/%h exp 0 0100/11", wr_n, address, wdata); end
        wait_phase(4'd15);
        rd_req = 1'b1; rd_addr = 16'h1236; rdata = 32'hAABBCCDD;
        @(negedge clk);
        rd_req = 1'b0;
        vectors++; if (mreq_n !== 1'b0 || rd_n !== 1'b0 || address !== 16'h1236) begin miscompares++; $display("FAIL rd_issue got mreq=%b rd=%b addr=%h exp 0 0 1236", mreq_n, rd_n, address); end
        @(negedge clk);
        vectors++; if (mreq_n !== 1'b1 || rd_n !== 1'b1) begin miscompares++; $display("FAIL rd_one_cycle got mreq=%b rd=%b exp 1 1", mreq_n, rd_n); end
        repeat (6) @(negedge clk);
        vectors++; if (phase !== 4'd7 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL rd_early got ph=%0d rv=%b exp 7 0", phase, rd_valid); end
        @(negedge clk);
        vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'hBB) begin miscompares++; $display("FAIL rd_data got rv=%b data=%h exp 1 bb", rd_valid, rd_data); end
        vectors++; if (wr_n !== 1'b0 || address !== 16'h0101 || wdata !== 8'h22) begin miscompares++; $display("FAIL wr1 got wr_n=%b %h/%h exp 0 0101/22", wr_n, address, wdata); end
        @(negedge clk);
        vectors++; if (rd_valid !== 1'b0 || level !== 3'd1) begin miscompares++; $display("FAIL rd_after got rv=%b lvl=%0d exp 0 1", rd_valid, level); end
        wait_phase(4'd8);
        vectors++; if (wr_n !== 1'b0 || address !== 16'h0102 || wdata !== 8'h33) begin miscompares++; $display("FAIL wr2 got wr_n=%b %h/%h exp 0 0102/33", wr_n, address, wdata); end
    endtask

    task automatic test_empty_refresh();
        wait_phase(4'd14);
        rd_req = 1'b1; rd_addr = 16'h0777;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        vectors++; if (rd_n !== 1'b1 || mreq_n !== 1'b1) begin miscompares++; $display("FAIL rd_off_phase got rd=%b mreq=%b exp 1 1", rd_n, mreq_n); end
        for (int i = 0; i < 2; i++) begin
            wait_phase(4'd8);
            vectors++; if (rfsh_n !== 1'b0 || mreq_n !== 1'b0 || wr_n !== 1'b1) begin miscompares++; $display("FAIL empty_rfsh%0d got rfsh=%b mreq=%b wr=%b exp 0 0 1", i, rfsh_n, mreq_n, wr_n); end
        end
        @(negedge clk);
        vectors++; if (rfsh_n !== 1'b1 || mreq_n !== 1'b1) begin miscompares++; $display("FAIL rfsh_one_cycle got rfsh=%b mreq=%b exp 1 1", rfsh_n, mreq_n); end
    endtask

    task automatic test_back_to_back();
        int k = 0, blocked = 0, acc_ph = -1;
        logic r;
        string pat = "WWWWRW";
        slot_log.delete(); wr_log.delete();
        for (int c = 0; c < 64 && k < 5; c++) begin
            wr_valid = 1'b1; wr_addr = 16'h2000 + 16'(k); wr_data = 8'hA0 + 8'(k);
            r = wr_ready;
            if (!r) blocked++;
            if (r && k == 4) acc_ph = int'(phase);
            @(negedge clk);
            if (r) begin
                k++;
                if (k == 4) begin
                    vectors++; if (wr_ready !== 1'b0 || level !== 3'd4) begin miscompares++; $display("FAIL full got rdy=%b lvl=%0d exp 0 4", wr_ready, level); end
                end
            end
        end
        wr_valid = 1'b0;
        vectors++; if (blocked != 12 || acc_ph != 9) begin miscompares++; $display("FAIL held_5th got blocked=%0d phase=%0d exp 12 9", blocked, acc_ph); end
        wait_slots(6);
        for (int i = 0; i < 6; i++) begin
            vectors++; if (slot_log[i] !== pat[i]) begin miscompares++; $display("FAIL b2b_slot%0d got=%c exp=%c", i, slot_log[i], pat[i]); end
        end
        for (int i = 0; i < 5; i++) begin
            vectors++; if (wr_log[i] !== {16'h2000 + 16'(i), 8'hA0 + 8'(i)}) begin miscompares++; $display("FAIL b2b_wr%0d got=%h exp=%h", i, wr_log[i], {16'h2000 + 16'(i), 8'hA0 + 8'(i)}); end
        end
    endtask

    task automatic test_refresh_sequence();
        int n = 0;
        logic r;
        string pat = "WWWWRWWWWR";
        wait_slots(7);
        vectors++; if (slot_log[6] !== "R") begin miscompares++; $display("FAIL pre_seq_slot got=%c exp=R", slot_log[6]); end
        slot_log.delete(); wr_log.delete();
        for (int c = 0; c < 300 && slot_log.size() < 10; c++) begin
            wr_valid = 1'b1; wr_addr = 16'(n); wr_data = 8'(n);
            r = wr_ready;
            @(negedge clk);
            if (r) n++;
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vectors++; if (slot_log[i] !== pat[i]) begin miscompares++; $display("FAIL seq_slot%0d got=%c exp=%c", i, slot_log[i], pat[i]); end
        end
        for (int i = 0; i < 8; i++) begin
            vectors++; if (wr_log[i] !== {16'(i), 8'(i)}) begin miscompares++; $display("FAIL seq_wr%0d got=%h exp=%h", i, wr_log[i], {16'(i), 8'(i)}); end
        end
        vectors++; if (n != 12 || level !== 3'd4) begin miscompares++; $display("FAIL seq_fill got pushed=%0d lvl=%0d exp 12 4", n, level); end
    endtask

    task automatic test_sync();
        int rv0 = rv_cnt;
        wait_phase(4'd15);
        rd_req = 1'b1; rd_addr = 16'h0042; rdata = 32'h11223344;
        @(negedge clk);
        rd_req = 1'b0;
        vectors++; if (rd_n !== 1'b0 || address !== 16'h0042) begin miscompares++; $display("FAIL sync_rd_issue got rd=%b addr=%h exp 0 0042", rd_n, address); end
        repeat (3) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        vectors++; if (phase !== 4'd0) begin miscompares++; $display("FAIL sync_phase got=%0d exp=0", phase); end
        wait_phase(4'd7);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        vectors++; if (phase !== 4'd0 || mreq_n !== 1'b1 || wr_n !== 1'b1 || level !== 3'd4) begin miscompares++; $display("FAIL sync_cancel got ph=%0d mreq=%b wr=%b lvl=%0d exp 0 1 1 4", phase, mreq_n, wr_n, level); end
        wait_phase(4'd8);
        vectors++; if (wr_n !== 1'b0 || address !== 16'h0008 || wdata !== 8'h08) begin miscompares++; $display("FAIL sync_head got wr=%b %h/%h exp 0 0008/08", wr_n, address, wdata); end
        @(negedge clk);
        vectors++; if (rv_cnt != rv0 || level !== 3'd3) begin miscompares++; $display("FAIL sync_abort got pulses=%0d lvl=%0d exp 0 3", rv_cnt - rv0, level); end
    endtask

    task automatic test_reset_mid();
        int rv0;
        wait_phase(4'd15);
        rd_req = 1'b1; rd_addr = 16'h0003;
        @(negedge clk);
        rd_req = 1'b0;
        vectors++; if (rd_n !== 1'b0) begin miscompares++; $display("FAIL rstm_rd_issue got rd=%b exp 0", rd_n); end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (phase !== 4'd0 || level !== 3'd0 || {mreq_n, rd_n, wr_n, rfsh_n} !== 4'hF || address !== 16'h0) begin miscompares++; $display("FAIL rstm_async got ph=%0d lvl=%0d str=%b addr=%h exp 0 0 1111 0000", phase, level, {mreq_n, rd_n, wr_n, rfsh_n}, address); end
        rv0 = rv_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        slot_log.delete(); wr_log.delete();
        wait_slots(2);
        vectors++; if (slot_log[0] !== "R" || slot_log[1] !== "R" || wr_log.size() != 0) begin miscompares++; $display("FAIL rstm_flush got slots=%c%c writes=%0d exp RR 0", slot_log[0], slot_log[1], wr_log.size()); end
        vectors++; if (rv_cnt != rv0 || level !== 3'd0) begin miscompares++; $display("FAIL rstm_abort got pulses=%0d lvl=%0d exp 0 0", rv_cnt - rv0, level); end
    endtask

    initial begin
        sync = 1'b0; busy = 1'b0; rd_req = 1'b0; rd_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rdata = '0;
        #1 rst_n = 1'b0;
        test_reset();
        test_init_busy();
        test_read();
        test_empty_refresh();
        test_back_to_back();
        test_refresh_sequence();
        test_sync();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
